uart_tx_block: RTL
==================

Name: uart_tx_block

Overview:
Serial transmit end of the team's UART link. It accepts one parallel data word through a valid/ready handshake and frames it as start bit, data bits (LSB first), optional even parity bit and stop bit. It drives a single registered serial line, holding each bit for CLKS_PER_BIT clocks. It sits between the parallel data source and the pad, opposite the existing serial-to-parallel receive path.

Parameters:
NUM_DATA_BITS, 8, data bits per frame (legal range 5-16)
CLKS_PER_BIT, 10, clocks per bit period (legal minimum 2)
PARITY_EN, 0, 1 = insert even parity bit after the data bits; 0 = no parity bit

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
tx_data  in  NUM_DATA_BITS  word to transmit; sampled only on handshake
tx_valid  in  1  source has a word on tx_data
tx_ready  out  1  block can accept a word this cycle
serial_out  out  1  registered serial line; idle level 1
tx_done  out  1  one-cycle pulse at the end of each completed frame

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high. rst is sampled at the rising edge of clk and overrides all other inputs.
- Reset values: serial_out=1, tx_ready=1, tx_done=0, state=IDLE, bit timer=0, bit counter=0.
- Handshake: a word is accepted when tx_valid=1 and tx_ready=1 at a rising edge. tx_data is captured into the shift register at that edge.
- tx_valid while tx_ready=0 is ignored, and tx_data is not sampled.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: serial_out=1, tx_ready=1. On handshake, go to START.
  - START: serial_out=0 for CLKS_PER_BIT clocks, then go to DATA.
  - DATA: serial_out=shift register LSB. Shift right once per bit period. Stay for NUM_DATA_BITS periods, then go to PARITY if PARITY_EN=1, else STOP.
  - PARITY: serial_out=XOR of the captured word (even parity, computed at capture). One bit period, then go to STOP.
  - STOP: serial_out=1 for one bit period, then go to IDLE.
- Latency: serial_out first shows the start bit (0) on the cycle after the accepting edge.
- Frame length is (2 + NUM_DATA_BITS + PARITY_EN) * CLKS_PER_BIT clocks.
- Bit timer counts 0..CLKS_PER_BIT-1. bit_done = (timer == CLKS_PER_BIT-1). The timer wraps to 0 on bit_done and on every state entry.
- tx_ready is 1 in IDLE and also during the last clock of STOP (timer == CLKS_PER_BIT-1).
- Back-to-back frames: a handshake in the last STOP clock goes directly to START with no extra idle clock. tx_done still pulses in that cycle.
- tx_done=1 for exactly one clock, registered, coincident with the first clock after the stop bit period ends (the first IDLE or START clock).
- Reset mid-frame aborts the frame: serial_out=1 on the next clock, state=IDLE, no tx_done pulse, and the partial word is discarded.
- Data bits are transmitted LSB first. No tx_data bits are lost or reordered for any NUM_DATA_BITS in the legal range.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Package uart_tx_pkg contains:
  - typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP}
  - localparam widths for the bit timer ($clog2(CLKS_PER_BIT)) and bit counter ($clog2(NUM_DATA_BITS+1)), derived in the module from the parameters
- Sub-module flex_pts_sr (parameters NUM_BITS, SHIFT_MSB): parallel-to-serial shift register with load_enable, shift_enable, parallel_in, serial_out.
  - Instantiated with NUM_BITS=NUM_DATA_BITS and SHIFT_MSB=0.
  - Load has priority over shift.
- The FSM, bit timer, bit counter and parity register live in uart_tx_block.

Test Plan:
1. Reset: hold rst=1 for 3 clocks with tx_valid=1 -> serial_out=1, tx_ready=1, tx_done=0 throughout, and no frame starts.
2. Defaults, single 0xA5: handshake at edge T -> serial_out=0 for clocks T+1..T+10, then bits 1,0,1,0,0,1,0,1 for 10 clocks each, then 1 for 10 clocks. tx_done pulses at T+101. tx_ready=0 from T+1 to T+99 and 1 at T+100.
3. Back-to-back 0x00 then 0xFF, tx_valid held high -> second start bit begins exactly 100 clocks after the first. Line pattern is start, eight 0s, stop, start, eight 1s, stop, with no gaps. Two tx_done pulses occur, 100 clocks apart.
4. Busy drop: tx_valid=1 with tx_data=0x3C at clocks T+20..T+30 during the 0xA5 frame -> 0x3C is never transmitted and the 0xA5 waveform is unchanged.
5. PARITY_EN=1, tx_data=0x07 -> parity bit=1 during clocks T+91..T+100, stop bit T+101..T+110, tx_done at T+111. With tx_data=0x03 the parity bit is 0.
6. Abort: rst=1 at clock T+45 of a 0xA5 frame -> serial_out=1, tx_ready=1 at the next clock, and no tx_done. A following 0x5A frame is bit-exact: bits 0,1,0,1,1,0,1,0, LSB first.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types for the UART transmit path.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/flex_pts_sr.sv
// Parallel-to-serial shift register; load wins over shift, vacated bits fill with 1.
module flex_pts_sr #(
  parameter int NUM_BITS  = 8,
  parameter bit SHIFT_MSB = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_enable,
  input  logic                shift_enable,
  input  logic [NUM_BITS-1:0] parallel_in,
  output logic                serial_out
);

  logic [NUM_BITS-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '1;
    end else if (load_enable) begin
      sr <= parallel_in;
    end else if (shift_enable) begin
      if (SHIFT_MSB) sr <= {sr[NUM_BITS-2:0], 1'b1};
      else           sr <= {1'b1, sr[NUM_BITS-1:1]};
    end
  end

  assign serial_out = SHIFT_MSB ? sr[NUM_BITS-1] : sr[0];

endmodule

// File: rtl/uart_tx_block.sv
// UART transmitter: valid/ready word in, start/data(LSB first)/[even parity]/stop out.
// All outputs are registered from next-state values so the line moves on the accepting edge.
module uart_tx_block
  import uart_tx_pkg::*;
#(
  parameter int NUM_DATA_BITS = 8,
  parameter int CLKS_PER_BIT  = 10,
  parameter int PARITY_EN     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_DATA_BITS-1:0] tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic                     serial_out,
  output logic                     tx_done
);

  localparam int TIMER_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W   = $clog2(NUM_DATA_BITS + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST     = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [TIMER_W-1:0] TIMER_PRESHIFT = TIMER_W'(CLKS_PER_BIT - 2);
  localparam logic [CNT_W-1:0]   CNT_LAST       = CNT_W'(NUM_DATA_BITS - 1);

  tx_state_t          state, state_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic               parity_q;
  logic               accept, bit_done, sr_lsb, shift;
  logic               line_nxt, ready_nxt, done_nxt;

  assign accept   = tx_valid & tx_ready;
  assign bit_done = (timer == TIMER_LAST);
  // Shift one clock before the bit boundary so the registered line picks up
  // the next data bit exactly on the boundary edge.
  assign shift    = (state == DATA) && (timer == TIMER_PRESHIFT);

  flex_pts_sr #(
    .NUM_BITS  (NUM_DATA_BITS),
    .SHIFT_MSB (1'b0)
  ) u_sr (
    .clk          (clk),
    .rst          (rst),
    .load_enable  (accept),
    .shift_enable (shift),
    .parallel_in  (tx_data),
    .serial_out   (sr_lsb)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = START;
      START:   if (bit_done) state_nxt = DATA;
      DATA:    if (bit_done && bit_cnt == CNT_LAST)
                 state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (bit_done) state_nxt = STOP;
      STOP:    if (bit_done) state_nxt = accept ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    timer_nxt   = timer + TIMER_W'(1);
    bit_cnt_nxt = bit_cnt;
    line_nxt    = 1'b1;
    if (state_nxt != state || bit_done || state_nxt == IDLE) timer_nxt = '0;
    if (state_nxt != state) bit_cnt_nxt = '0;
    else if (state == DATA && bit_done) bit_cnt_nxt = bit_cnt + CNT_W'(1);
    case (state_nxt)
      START:   line_nxt = 1'b0;
      DATA:    line_nxt = sr_lsb;
      PARITY:  line_nxt = parity_q;
      default: line_nxt = 1'b1;
    endcase
    ready_nxt = (state_nxt == IDLE) || (state_nxt == STOP && timer_nxt == TIMER_LAST);
    done_nxt  = (state == STOP) && bit_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      bit_cnt    <= '0;
      parity_q   <= 1'b0;
      serial_out <= 1'b1;
      tx_ready   <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      bit_cnt    <= bit_cnt_nxt;
      serial_out <= line_nxt;
      tx_ready   <= ready_nxt;
      tx_done    <= done_nxt;
      if (accept) parity_q <= ^tx_data;
    end
  end

endmodule
